// File: rtl/rf_scoreboard_if.sv
// Issue / writeback / status bundle between the issue stage and rf_scoreboard.
interface rf_scoreboard_if #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CW   = 32
);
   logic            iss0_valid;
   logic [AW-1:0]   iss0_rs1;
   logic [AW-1:0]   iss0_rs2;
   logic [AW-1:0]   iss0_rd;
   logic            iss0_wen;
   logic            iss0_ready;
   logic            iss1_valid;
   logic [AW-1:0]   iss1_rs1;
   logic [AW-1:0]   iss1_rs2;
   logic [AW-1:0]   iss1_rd;
   logic            iss1_wen;
   logic            iss1_ready;
   logic            wb0_valid;
   logic [AW-1:0]   wb0_rd;
   logic            wb1_valid;
   logic [AW-1:0]   wb1_rd;
   logic            flush;
   logic [NREG-1:0] busy_vec;
   logic [CW-1:0]   stall_cnt;
   logic            err;

   modport master (
      output iss0_valid, iss0_rs1, iss0_rs2, iss0_rd, iss0_wen,
      output iss1_valid, iss1_rs1, iss1_rs2, iss1_rd, iss1_wen,
      output wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
      input  iss0_ready, iss1_ready, busy_vec, stall_cnt, err
   );

   modport slave (
      input  iss0_valid, iss0_rs1, iss0_rs2, iss0_rd, iss0_wen,
      input  iss1_valid, iss1_rs1, iss1_rs2, iss1_rd, iss1_wen,
      input  wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
      output iss0_ready, iss1_ready, busy_vec, stall_cnt, err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Dual-issue register scoreboard: one busy bit per architectural register,
// issue-ready generation for RAW/WAW/intra-pair hazards, stall counter and
// sticky writeback protocol-error flag. x0 never becomes busy.
module rf_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CW   = 32
) (
   input  logic             clock,
   input  logic             reset,
   rf_scoreboard_if.slave   bus
);

   logic [NREG-1:0] r_busy;
   logic [CW-1:0]   r_stall;
   logic            r_err;

   logic            w_w0;
   logic            w_w1;
   logic            w_rdy0;
   logic            w_rdy1;
   logic            w_fire0;
   logic            w_fire1;
   logic            w_raw1;
   logic            w_waw1;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_err_set;

   function automatic logic [NREG-1:0] f_onehot(input logic [AW-1:0] idx);
      logic [NREG-1:0] v;
      v      = {NREG{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Hazard checks use only the registered busy bits; a same-cycle writeback
   // does not unblock, which keeps the ready path short.
   always_comb begin
      w_w0    = bus.iss0_wen & (bus.iss0_rd != {AW{1'b0}});
      w_w1    = bus.iss1_wen & (bus.iss1_rd != {AW{1'b0}});
      w_rdy0  = ~bus.flush & ~r_busy[bus.iss0_rs1] & ~r_busy[bus.iss0_rs2]
                & ~(w_w0 & r_busy[bus.iss0_rd]);
      w_fire0 = bus.iss0_valid & w_rdy0;
      // w_w0 already implies iss0_rd is nonzero, so x0 sources never match
      w_raw1  = w_w0 & ((bus.iss1_rs1 == bus.iss0_rd) | (bus.iss1_rs2 == bus.iss0_rd));
      w_waw1  = w_w0 & w_w1 & (bus.iss1_rd == bus.iss0_rd);
      w_rdy1  = w_fire0 & ~bus.flush & ~r_busy[bus.iss1_rs1] & ~r_busy[bus.iss1_rs2]
                & ~(w_w1 & r_busy[bus.iss1_rd]) & ~w_raw1 & ~w_waw1;
      w_fire1 = bus.iss1_valid & w_rdy1;
   end

   // Next busy vector: issue sets win over writeback clears; flush wipes all.
   always_comb begin
      w_set = {NREG{1'b0}};
      w_clr = {NREG{1'b0}};
      if (w_fire0 && w_w0) begin
         w_set = w_set | f_onehot(bus.iss0_rd);
      end else begin
         w_set = w_set;
      end
      if (w_fire1 && w_w1) begin
         w_set = w_set | f_onehot(bus.iss1_rd);
      end else begin
         w_set = w_set;
      end
      if (bus.wb0_valid) begin
         w_clr = w_clr | f_onehot(bus.wb0_rd);
      end else begin
         w_clr = w_clr;
      end
      if (bus.wb1_valid) begin
         w_clr = w_clr | f_onehot(bus.wb1_rd);
      end else begin
         w_clr = w_clr;
      end
      if (bus.flush) begin
         w_busy_nxt = {NREG{1'b0}};
      end else begin
         w_busy_nxt = (r_busy & ~w_clr) | w_set;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Protocol errors: retiring a register that is not busy (ignored for x0
   // and during flush), or both buses retiring the same register at once.
   always_comb begin
      w_err_set = 1'b0;
      if (!bus.flush) begin
         w_err_set = (bus.wb0_valid & (bus.wb0_rd != {AW{1'b0}}) & ~r_busy[bus.wb0_rd])
                   | (bus.wb1_valid & (bus.wb1_rd != {AW{1'b0}}) & ~r_busy[bus.wb1_rd]);
      end else begin
         w_err_set = 1'b0;
      end
      if (bus.wb0_valid && bus.wb1_valid && (bus.wb0_rd == bus.wb1_rd)) begin
         w_err_set = 1'b1;
      end else begin
         w_err_set = w_err_set;
      end
   end

   // State registers: busy bits, saturating stall counter, sticky error.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_busy  <= {NREG{1'b0}};
         r_stall <= {CW{1'b0}};
         r_err   <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (bus.iss0_valid && !w_rdy0 && (r_stall != {CW{1'b1}})) begin
            r_stall <= r_stall + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            r_stall <= r_stall;
         end
         r_err <= r_err | w_err_set;
      end
   end

   assign bus.iss0_ready = w_rdy0;
   assign bus.iss1_ready = w_rdy1;
   assign bus.busy_vec   = r_busy;
   assign bus.stall_cnt  = r_stall;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard: a reference model predicts the readies
// each cycle and pushes the predicted registered state, which is popped and
// compared after the clock edge. A second narrow-counter instance exercises
// stall counter saturation.
module tb_rf_scoreboard;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int CW   = 32;
   localparam int SCW  = 4;

   typedef struct {
      logic [31:0] busy;
      logic [31:0] stall;
      logic        err;
   } exp_t;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   logic [31:0] m_busy;
   logic [31:0] m_stall;
   logic        m_err;
   logic [SCW-1:0] m_sat;

   rf_scoreboard_if #(.NREG(NREG), .AW(AW), .CW(CW))  sb_if ();
   rf_scoreboard_if #(.NREG(NREG), .AW(AW), .CW(SCW)) sat_if ();

   rf_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (sb_if.slave)
   );

   rf_scoreboard #(.NREG(NREG), .AW(AW), .CW(SCW)) u_dut_sat (
      .clock (clock),
      .reset (reset),
      .bus   (sat_if.slave)
   );

   // free-running clock, posedge at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      sb_if.iss0_valid = 1'b0; sb_if.iss0_rs1 = 5'd0; sb_if.iss0_rs2 = 5'd0;
      sb_if.iss0_rd    = 5'd0; sb_if.iss0_wen = 1'b0;
      sb_if.iss1_valid = 1'b0; sb_if.iss1_rs1 = 5'd0; sb_if.iss1_rs2 = 5'd0;
      sb_if.iss1_rd    = 5'd0; sb_if.iss1_wen = 1'b0;
      sb_if.wb0_valid  = 1'b0; sb_if.wb0_rd   = 5'd0;
      sb_if.wb1_valid  = 1'b0; sb_if.wb1_rd   = 5'd0;
      sb_if.flush      = 1'b0;
   endtask

   task automatic iss0(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
      sb_if.iss0_valid = 1'b1; sb_if.iss0_rs1 = rs1; sb_if.iss0_rs2 = rs2;
      sb_if.iss0_rd    = rd;   sb_if.iss0_wen = wen;
   endtask

   task automatic iss1(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
      sb_if.iss1_valid = 1'b1; sb_if.iss1_rs1 = rs1; sb_if.iss1_rs2 = rs2;
      sb_if.iss1_rd    = rd;   sb_if.iss1_wen = wen;
   endtask

   task automatic wb(input logic v0, input logic [4:0] rd0, input logic v1, input logic [4:0] rd1);
      sb_if.wb0_valid = v0; sb_if.wb0_rd = rd0;
      sb_if.wb1_valid = v1; sb_if.wb1_rd = rd1;
   endtask

   // One clock cycle with the currently driven inputs: check readies against
   // the model, predict the next registered state, then compare after the edge.
   task automatic cyc(input string tag);
      logic w0, w1, r0, r1, f0, f1;
      logic [31:0] set_v, clr_v;
      exp_t e;
      #2;
      w0 = sb_if.iss0_wen && (sb_if.iss0_rd != 5'd0);
      w1 = sb_if.iss1_wen && (sb_if.iss1_rd != 5'd0);
      r0 = !sb_if.flush && !m_busy[sb_if.iss0_rs1] && !m_busy[sb_if.iss0_rs2]
           && !(w0 && m_busy[sb_if.iss0_rd]);
      f0 = sb_if.iss0_valid && r0;
      r1 = f0 && !sb_if.flush && !m_busy[sb_if.iss1_rs1] && !m_busy[sb_if.iss1_rs2]
           && !(w1 && m_busy[sb_if.iss1_rd])
           && !(w0 && ((sb_if.iss1_rs1 == sb_if.iss0_rd) || (sb_if.iss1_rs2 == sb_if.iss0_rd)))
           && !(w0 && w1 && (sb_if.iss1_rd == sb_if.iss0_rd));
      f1 = sb_if.iss1_valid && r1;
      if (reset) begin
         check_val({tag, ".rdy0"}, {31'd0, sb_if.iss0_ready}, {31'd0, r0});
         check_val({tag, ".rdy1"}, {31'd0, sb_if.iss1_ready}, {31'd0, r1});
      end
      set_v = 32'd0;
      clr_v = 32'd0;
      if (f0 && w0) set_v[sb_if.iss0_rd] = 1'b1;
      if (f1 && w1) set_v[sb_if.iss1_rd] = 1'b1;
      if (sb_if.wb0_valid) clr_v[sb_if.wb0_rd] = 1'b1;
      if (sb_if.wb1_valid) clr_v[sb_if.wb1_rd] = 1'b1;
      e.busy  = sb_if.flush ? 32'd0 : (((m_busy & ~clr_v) | set_v) & ~32'd1);
      e.stall = (sb_if.iss0_valid && !r0 && (m_stall != 32'hFFFF_FFFF)) ? m_stall + 32'd1 : m_stall;
      e.err   = m_err
              || (!sb_if.flush && sb_if.wb0_valid && (sb_if.wb0_rd != 5'd0) && !m_busy[sb_if.wb0_rd])
              || (!sb_if.flush && sb_if.wb1_valid && (sb_if.wb1_rd != 5'd0) && !m_busy[sb_if.wb1_rd])
              || (sb_if.wb0_valid && sb_if.wb1_valid && (sb_if.wb0_rd == sb_if.wb1_rd));
      if (!reset) begin
         e.busy  = 32'd0;
         e.stall = 32'd0;
         e.err   = 1'b0;
      end
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check_val({tag, ".busy"},  sb_if.busy_vec,  e.busy);
      check_val({tag, ".stall"}, sb_if.stall_cnt, e.stall);
      check_val({tag, ".err"},   {31'd0, sb_if.err}, {31'd0, e.err});
      m_busy  = e.busy;
      m_stall = e.stall;
      m_err   = e.err;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      m_busy = 32'd0; m_stall = 32'd0; m_err = 1'b0;
      idle();
      sat_if.iss0_valid = 1'b0; sat_if.iss0_rs1 = 5'd0; sat_if.iss0_rs2 = 5'd0;
      sat_if.iss0_rd    = 5'd0; sat_if.iss0_wen = 1'b0;
      sat_if.iss1_valid = 1'b0; sat_if.iss1_rs1 = 5'd0; sat_if.iss1_rs2 = 5'd0;
      sat_if.iss1_rd    = 5'd0; sat_if.iss1_wen = 1'b0;
      sat_if.wb0_valid  = 1'b0; sat_if.wb0_rd   = 5'd0;
      sat_if.wb1_valid  = 1'b0; sat_if.wb1_rd   = 5'd0;
      sat_if.flush      = 1'b0;
      reset = 1'b0;
      cyc("rst0");
      cyc("rst1");
      reset = 1'b1;
      cyc("post_rst");

      // single issue: sets busy[3]
      iss0(5'd1, 5'd2, 5'd3, 1'b1); cyc("iss_rd3");
      // RAW against busy[3] stalls and counts
      iss0(5'd3, 5'd0, 5'd10, 1'b1);
      for (int i = 0; i < 3; i++) cyc("raw_stall");
      // writeback in the same cycle does not unblock
      wb(1'b1, 5'd3, 1'b0, 5'd0); cyc("wb_same");
      wb(1'b0, 5'd0, 1'b0, 5'd0); cyc("wb_after");
      idle(); wb(1'b1, 5'd10, 1'b0, 5'd0); cyc("clr10");

      // intra-pair RAW
      idle(); iss0(5'd0, 5'd0, 5'd5, 1'b1); iss1(5'd0, 5'd5, 5'd11, 1'b1); cyc("pair_raw");
      idle(); wb(1'b1, 5'd5, 1'b0, 5'd0); cyc("clr5");
      // intra-pair WAW
      idle(); iss0(5'd0, 5'd0, 5'd6, 1'b1); iss1(5'd0, 5'd0, 5'd6, 1'b1); cyc("pair_waw");
      idle(); wb(1'b1, 5'd6, 1'b0, 5'd0); cyc("clr6");
      // independent pair, both fire
      idle(); iss0(5'd0, 5'd0, 5'd7, 1'b1); iss1(5'd0, 5'd0, 5'd8, 1'b1); cyc("pair_ok");
      idle(); wb(1'b1, 5'd7, 1'b1, 5'd8); cyc("clr78");

      // x0 destination never goes busy; x0 source never blocks
      idle(); iss0(5'd0, 5'd0, 5'd0, 1'b1); cyc("rd0");
      iss0(5'd0, 5'd0, 5'd9, 1'b0); cyc("rs0");

      // dual writeback, then error cases
      idle(); iss0(5'd0, 5'd0, 5'd4, 1'b1); iss1(5'd0, 5'd0, 5'd5, 1'b1); cyc("set45");
      idle(); wb(1'b1, 5'd4, 1'b1, 5'd5); cyc("wb45");
      idle(); wb(1'b1, 5'd9, 1'b0, 5'd0); cyc("err_nbusy");
      idle(); wb(1'b1, 5'd4, 1'b1, 5'd4); cyc("err_dup");
      // set wins over clear on the same register
      idle(); iss0(5'd0, 5'd0, 5'd12, 1'b1); wb(1'b1, 5'd12, 1'b0, 5'd0); cyc("set_wins");

      // reset mid-operation discards everything
      idle(); iss0(5'd12, 5'd0, 5'd1, 1'b1); reset = 1'b0; cyc("mid_rst");
      reset = 1'b1; idle(); cyc("after_rst");

      // flush with pending writes
      iss0(5'd0, 5'd0, 5'd4, 1'b1); iss1(5'd0, 5'd0, 5'd5, 1'b1); cyc("set45b");
      idle(); iss0(5'd0, 5'd0, 5'd6, 1'b1); iss1(5'd0, 5'd0, 5'd7, 1'b1); cyc("set67");
      idle(); iss0(5'd1, 5'd2, 5'd3, 1'b1); wb(1'b1, 5'd4, 1'b0, 5'd0); sb_if.flush = 1'b1;
      cyc("flush");
      wb(1'b1, 5'd9, 1'b0, 5'd0); cyc("flush_wb_nbusy");
      idle(); cyc("idle_end");

      // stall counter saturation on the narrow-counter instance
      sat_if.flush = 1'b1;
      sat_if.iss0_valid = 1'b1;
      m_sat = 4'd0;
      #2;
      check_val("sat.rdy0", {31'd0, sat_if.iss0_ready}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         m_sat = (m_sat == 4'hF) ? 4'hF : m_sat + 4'd1;
         check_val("sat.stall", {28'd0, sat_if.stall_cnt}, {28'd0, m_sat});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
